// File: rtl/seq_int_div.sv
// Multi-cycle restoring integer divider with start/done handshake.
// Signed operands are divided as magnitudes; signs are reapplied before the result load.
module seq_int_div #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dmag;
    logic             q_neg;
    logic             r_neg;

    logic             accept;
    logic             zero_div;
    logic             last_iter;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH+1:0] diff;

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign zero_div  = (divisor == '0);
    assign last_iter = (cnt == CW'(WIDTH - 1));

    // Unsigned WIDTH-bit negation keeps MIN's magnitude exact.
    assign a_mag = (signed_mode && dividend[WIDTH-1]) ? -dividend : dividend;
    assign b_mag = (signed_mode && divisor[WIDTH-1])  ? -divisor  : divisor;

    // Trial subtract on the shifted partial remainder; the top bit is the borrow.
    assign diff = {rem, quo[WIDTH-1]} - {2'b00, dmag};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = zero_div ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_nx = FIX;
                end
            end
            FIX: begin
                busy     = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nx = zero_div ? DONE : CALC;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            dmag        <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            rem   <= '0;
            quo   <= a_mag;
            dmag  <= b_mag;
            q_neg <= signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg <= signed_mode & dividend[WIDTH-1];
            if (zero_div) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == CALC) begin
            cnt <= cnt + CW'(1);
            quo <= {quo[WIDTH-2:0], ~diff[WIDTH+1]};
            rem <= diff[WIDTH+1] ? {rem[WIDTH-1:0], quo[WIDTH-1]} : diff[WIDTH:0];
        end else if (state == FIX) begin
            quotient    <= q_neg ? -quo : quo;
            remainder   <= r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
            div_by_zero <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_int_div.sv
// Self-checking bench for seq_int_div: WIDTH 8/16/32 instances against an arithmetic model.
module tb_seq_int_div;

    typedef struct packed {
        logic [63:0] q;
        logic [63:0] r;
        logic        dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        st8, sm8, by8, dn8, dz8;
    logic [7:0]  a8, b8, q8, r8;
    logic        st16, sm16, by16, dn16, dz16;
    logic [15:0] a16, b16, q16, r16;
    logic        st32, sm32, by32, dn32, dz32;
    logic [31:0] a32, b32, q32, r32;

    seq_int_div #(.WIDTH(8)) d8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .signed_mode(sm8), .dividend(a8), .divisor(b8),
        .busy(by8), .done(dn8), .quotient(q8), .remainder(r8), .div_by_zero(dz8));
    seq_int_div #(.WIDTH(16)) d16 (
        .clk(clk), .rst_n(rst_n), .start(st16), .signed_mode(sm16), .dividend(a16), .divisor(b16),
        .busy(by16), .done(dn16), .quotient(q16), .remainder(r16), .div_by_zero(dz16));
    seq_int_div #(.WIDTH(32)) d32 (
        .clk(clk), .rst_n(rst_n), .start(st32), .signed_mode(sm32), .dividend(a32), .divisor(b32),
        .busy(by32), .done(dn32), .quotient(q32), .remainder(r32), .div_by_zero(dz32));

    int   vec = 0;
    int   errs = 0;
    exp_t expq [3][$];
    exp_t held [3];

    function automatic int wid(input int k);
        return (k == 0) ? 8 : (k == 1) ? 16 : 32;
    endfunction

    function automatic logic [63:0] mask(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // Reference: plain integer arithmetic on sign-extended values.
    function automatic exp_t model(input int w, input bit sm, input logic [63:0] a_in, input logic [63:0] b_in);
        exp_t        e;
        logic [63:0] m;
        logic [63:0] a;
        logic [63:0] b;
        longint      sa;
        longint      sb;
        m = mask(w);
        a = a_in & m;
        b = b_in & m;
        if (b == 64'd0) begin
            e.q = m; e.r = a; e.dz = 1'b1;
        end else if (!sm) begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0;
        end else begin
            sa = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
            sb = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
            e.q = 64'(sa / sb) & m;
            e.r = 64'(sa % sb) & m;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [63:0] gen(input int w);
        int unsigned s;
        s = $urandom_range(0, 7);
        case (s)
            0:       return 64'd0;
            1:       return 64'd1 << (w - 1);
            2:       return mask(w);
            3:       return 64'($urandom_range(1, 9));
            default: return {$urandom, $urandom} & mask(w);
        endcase
    endfunction

    task automatic cmp(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s (w%0d) got %h expected %h at %0t", nm, wid(k), act, exp, $time);
        end
    endtask

    task automatic drive(input int k, input logic s, input logic m, input logic [63:0] a, input logic [63:0] b);
        case (k)
            0:       begin st8  = s; sm8  = m; a8  = a[7:0];  b8  = b[7:0];  end
            1:       begin st16 = s; sm16 = m; a16 = a[15:0]; b16 = b[15:0]; end
            default: begin st32 = s; sm32 = m; a32 = a[31:0]; b32 = b[31:0]; end
        endcase
    endtask

    function automatic logic get_done(input int k);
        return (k == 0) ? dn8 : (k == 1) ? dn16 : dn32;
    endfunction

    function automatic logic get_busy(input int k);
        return (k == 0) ? by8 : (k == 1) ? by16 : by32;
    endfunction

    // Called at posedge+1; returns at posedge+1 of the done cycle so the next call is back-to-back.
    task automatic do_op(input int k, input bit sm, input logic [63:0] a, input logic [63:0] b, input int poke);
        int w;
        int edges;
        int busyc;
        int exp_edges;
        w = wid(k);
        expq[k].push_back(model(w, sm, a, b));
        exp_edges = ((b & mask(w)) == 64'd0) ? 1 : w + 2;
        drive(k, 1'b1, sm, a, b);
        @(posedge clk); #1;
        edges = 1;
        busyc = 0;
        drive(k, 1'b0, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
        while (!get_done(k) && edges < w + 8) begin
            if (get_busy(k)) busyc++;
            drive(k, (edges == poke), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
            @(posedge clk); #1;
            edges++;
        end
        drive(k, 1'b0, 1'b0, 64'd0, 64'd0);
        cmp("latency", k, 64'(edges), 64'(exp_edges));
        cmp("busy_cycles", k, 64'(busyc), 64'(exp_edges - 1));
    endtask

    task automatic chk(input int k, input logic dn, input logic bsy, input logic [63:0] q,
                       input logic [63:0] r, input logic dz);
        exp_t e;
        if (!rst_n) begin
            cmp("reset_q", k, q, 64'd0);
            cmp("reset_r", k, r, 64'd0);
            cmp("reset_ctl", k, 64'({dn, bsy, dz}), 64'd0);
            expq[k].delete();
            held[k] = '0;
        end else if (dn) begin
            cmp("busy_on_done", k, 64'(bsy), 64'd0);
            if (expq[k].size() == 0) begin
                vec++;
                errs++;
                $display("FAIL unexpected_done (w%0d) got done=1 expected none at %0t", wid(k), $time);
            end else begin
                e = expq[k].pop_front();
                cmp("quotient", k, q, e.q);
                cmp("remainder", k, r, e.r);
                cmp("div_by_zero", k, 64'(dz), 64'(e.dz));
                held[k] = e;
            end
        end else begin
            cmp("hold_q", k, q, held[k].q);
            cmp("hold_r", k, r, held[k].r);
            cmp("hold_dz", k, 64'(dz), 64'(held[k].dz));
        end
    endtask

    always @(negedge clk) begin
        chk(0, dn8,  by8,  64'(q8),  64'(r8),  dz8);
        chk(1, dn16, by16, 64'(q16), 64'(r16), dz16);
        chk(2, dn32, by32, 64'(q32), 64'(r32), dz32);
    end

    task automatic rnd_ops(input int k, input int n);
        int w;
        int poke;
        w = wid(k);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            poke = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, w - 1)) : 0;
            do_op(k, 1'($urandom), gen(w), gen(w), poke);
        end
    endtask

    exp_t m;
    int   nd;

    initial begin
        for (int k = 0; k < 3; k++) begin
            drive(k, 1'b0, 1'b0, 64'd0, 64'd0);
            held[k] = '0;
        end

        m = model(16, 1'b0, 64'd1000, 64'd7);
        cmp("model_u", 1, m.q, 64'd142);
        cmp("model_u_r", 1, m.r, 64'd6);
        m = model(16, 1'b1, 64'hFF9C, 64'h7);
        cmp("model_s", 1, {m.q[31:0], m.r[31:0]}, 64'h0000FFF2_0000FFFE);
        m = model(16, 1'b1, 64'h8000, 64'hFFFF);
        cmp("model_min", 1, {m.q[31:0], m.r[31:0]}, 64'h00008000_00000000);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cmp("post_reset_q", 1, 64'(q16), 64'd0);
        @(posedge clk); #1;

        do_op(1, 1'b0, 64'd1000, 64'd7, 0);
        cmp("t1_q", 1, 64'(q16), 64'd142);
        cmp("t1_r", 1, 64'(r16), 64'd6);
        do_op(1, 1'b1, 64'hFF9C, 64'h0007, 0);
        cmp("t2a", 1, 64'({q16, r16}), 64'hFFF2_FFFE);
        do_op(1, 1'b1, 64'h0064, 64'hFFF9, 0);
        cmp("t2b", 1, 64'({q16, r16}), 64'hFFF2_0002);
        do_op(1, 1'b0, 64'd1234, 64'd0, 0);
        cmp("t3a", 1, 64'({q16, r16, 15'd0, dz16}), 64'hFFFF_04D2_0001);
        do_op(1, 1'b0, 64'd9, 64'd3, 0);
        cmp("t3b", 1, 64'({q16, r16, 15'd0, dz16}), 64'h0003_0000_0000);
        do_op(1, 1'b1, 64'h8000, 64'hFFFF, 0);
        cmp("t4a", 1, 64'({q16, r16}), 64'h8000_0000);
        do_op(1, 1'b0, 64'h8000, 64'hFFFF, 0);
        cmp("t4b", 1, 64'({q16, r16}), 64'h0000_8000);
        do_op(1, 1'b0, 64'd1000, 64'd7, 5);
        cmp("t5_poke", 1, 64'({q16, r16}), 64'h008E_0006);

        // Abort an operation with reset mid-CALC.
        drive(1, 1'b1, 1'b0, 64'd1000, 64'd7);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        cmp("rst_mid_q", 1, 64'(q16), 64'd0);
        cmp("rst_mid_r", 1, 64'(r16), 64'd0);
        cmp("rst_mid_ctl", 1, 64'({dn16, by16, dz16}), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        nd = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (dn16) nd++;
        end
        cmp("rst_no_done", 1, 64'(nd), 64'd0);
        do_op(1, 1'b0, 64'd9, 64'd3, 0);
        cmp("t5_after_rst", 1, 64'({q16, r16}), 64'h0003_0000);

        fork
            rnd_ops(0, 400);
            rnd_ops(1, 400);
            rnd_ops(2, 400);
        join

        repeat (3) @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            cmp("pending_results", k, 64'(expq[k].size()), 64'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
